// File: rtl/seq_restoring_divider.sv
// Iterative unsigned radix-2 restoring divider with valid/ready handshakes.
// Produces one quotient bit per clock; a zero divisor short-circuits to a flagged result.
module seq_restoring_divider #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic [CNT_W-1:0] count;

    logic [WIDTH:0]   shifted_c;
    logic [WIDTH:0]   trial_c;
    logic [WIDTH-1:0] rem_nxt_c;
    logic [WIDTH-1:0] q_nxt_c;

    // One restoring step. The partial remainder stays below the divisor, so it
    // fits in WIDTH bits; only the shifted trial operand needs the extra bit.
    always_comb begin
        shifted_c = {rem_reg, q_reg[WIDTH-1]};
        trial_c   = shifted_c - {1'b0, divisor_reg};
        rem_nxt_c = trial_c[WIDTH] ? shifted_c[WIDTH-1:0] : trial_c[WIDTH-1:0];
        q_nxt_c   = {q_reg[WIDTH-2:0], ~trial_c[WIDTH]};
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            rem_reg     <= '0;
            q_reg       <= '0;
            divisor_reg <= '0;
            count       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            divisor_reg <= divisor;
                            rem_reg     <= '0;
                            q_reg       <= dividend;
                            count       <= '0;
                            state       <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_reg <= rem_nxt_c;
                    q_reg   <= q_nxt_c;
                    count   <= count + CNT_W'(1);
                    if (count == CNT_W'(WIDTH - 1)) begin
                        quotient    <= q_nxt_c;
                        remainder   <= rem_nxt_c;
                        div_by_zero <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed cases plus randomized
// operands with output stalls, checked against plain / and % arithmetic.
module tb_seq_restoring_divider;

    localparam int unsigned WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;

    seq_restoring_divider #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands until accepted, then scramble the inputs.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                step();
                break;
            end
            step();
        end
        in_valid = 1'b0;
        dividend = WIDTH'($urandom);
        divisor  = WIDTH'($urandom);
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    // Count edges after acceptance until out_valid is seen.
    task automatic wait_valid(input bit rand_ready, output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (rand_ready) out_ready = 1'($urandom);
            step();
            lat++;
        end
        if (!out_valid) check("valid_timeout", 32'd0, 32'd1);
    endtask

    // Reference model: plain arithmetic, zero divisor yields all-ones / dividend.
    task automatic check_result(input string tag, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input int lat);
        logic [WIDTH-1:0] eq;
        logic [WIDTH-1:0] er;
        logic [31:0]      recon;
        eq = (b == '0) ? '1 : a / b;
        er = (b == '0) ? a  : a % b;
        check({tag, "_lat"}, 32'(lat), (b == '0) ? 32'd0 : 32'd16);
        check({tag, "_q"},   32'(quotient),    32'(eq));
        check({tag, "_r"},   32'(remainder),   32'(er));
        check({tag, "_dbz"}, 32'(div_by_zero), (b == '0) ? 32'd1 : 32'd0);
        if (b != '0) begin
            recon = 32'(quotient) * 32'(b) + 32'(remainder);
            check({tag, "_inv"}, 32'((recon == 32'(a)) && (remainder < b)), 32'd1);
        end
    endtask

    // Run one operation with out_ready high and verify the handshake back to idle.
    task automatic run_simple(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int lat;
        out_ready = 1'b1;
        send(a, b);
        wait_valid(1'b0, lat);
        check_result(tag, a, b, lat);
        step();
        check({tag, "_ovalid_clr"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready"},   32'(in_ready),  32'd1);
    endtask

    int               lat;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    int               results;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready",  32'(in_ready),    32'd1);
        check("rst_out_valid", 32'(out_valid),   32'd0);
        check("rst_busy",      32'(busy),        32'd0);
        check("rst_q",         32'(quotient),    32'd0);
        check("rst_r",         32'(remainder),   32'd0);
        check("rst_dbz",       32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        step();

        run_simple("d100_7",    16'd100,   16'd7);
        run_simple("ffff_1",    16'hFFFF,  16'h0001);
        run_simple("ffff_ffff", 16'hFFFF,  16'hFFFF);
        run_simple("3_ffff",    16'h0003,  16'hFFFF);
        run_simple("zero_div",  16'd5,     16'd0);
        run_simple("zero_dvd",  16'd0,     16'd9);

        // Stall the consumer: result held, new operands ignored.
        out_ready = 1'b0;
        send(16'd100, 16'd7);
        wait_valid(1'b0, lat);
        check_result("stall", 16'd100, 16'd7, lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            dividend = 16'd999;
            divisor  = 16'd3;
            step();
            in_valid = 1'b0;
            check("stall_q",     32'(quotient),  32'd14);
            check("stall_r",     32'(remainder), 32'd2);
            check("stall_ovld",  32'(out_valid), 32'd1);
            check("stall_irdy",  32'(in_ready),  32'd0);
            check("stall_busy",  32'(busy),      32'd1);
        end
        out_ready = 1'b1;
        step();
        check("stall_release_irdy", 32'(in_ready), 32'd1);
        run_simple("after_stall", 16'd81, 16'd9);

        // Reset in the middle of a calculation.
        send(16'hABCD, 16'h0013);
        for (int i = 0; i < 7; i++) step();
        check("midcalc_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",  32'(busy),        32'd0);
        check("arst_irdy",  32'(in_ready),    32'd1);
        check("arst_ovld",  32'(out_valid),   32'd0);
        check("arst_q",     32'(quotient),    32'd0);
        check("arst_r",     32'(remainder),   32'd0);
        check("arst_dbz",   32'(div_by_zero), 32'd0);
        #3 rst_n = 1'b1;
        step();
        check("post_rst_irdy", 32'(in_ready), 32'd1);
        run_simple("d50_5", 16'd50, 16'd5);

        // Randomized operands with random consumer stalls.
        results = 0;
        for (int n = 0; n < 1000; n++) begin
            case ($urandom_range(0, 4))
                0: ra = '0;
                1: ra = '1;
                default: ra = WIDTH'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 16'd1;
                2: rb = '1;
                3: rb = WIDTH'($urandom_range(1, 15));
                default: rb = WIDTH'($urandom);
            endcase
            out_ready = 1'($urandom);
            send(ra, rb);
            wait_valid(1'b1, lat);
            check_result("rand", ra, rb, lat);
            results++;
            for (int k = 0; k < 20 && out_valid; k++) begin
                out_ready = (k >= 10) ? 1'b1 : 1'($urandom);
                step();
                if (out_valid) begin
                    check("rand_hold_q", 32'(quotient),  32'((rb == '0) ? 16'hFFFF : ra / rb));
                    check("rand_hold_r", 32'(remainder), 32'((rb == '0) ? ra : ra % rb));
                end
            end
            check("rand_consumed", 32'(out_valid), 32'd0);
            check("rand_idle_irdy", 32'(in_ready), 32'd1);
        end
        check("rand_count", 32'(results), 32'd1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
